// File: rtl/game_pkg.sv
// +--------------------------------------------------------------------+
// | game_pkg : shared types and constants for the game sequencer       |
// | Rev 1.0  : initial release                                         |
// +--------------------------------------------------------------------+
`default_nettype none

package game_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    OVER = 2'd2
  } state_e;

  localparam int SCREEN_W    = 640;
  localparam int SCREEN_H    = 480;
  localparam int SPRITE_SIZE = 32;
  localparam int SCORE_W     = 7;
  localparam int SPEED_MAX   = 7;

  // Folds the upper LFSR range back onto the screen; one subtraction
  // suffices while x_max >= 511.
  function automatic logic [9:0] spawn_col(input logic [9:0] v, input logic [9:0] x_max);
    return (v > x_max) ? v - (x_max + 10'd1) : v;
  endfunction

endpackage

`default_nettype wire

// File: rtl/lfsr10.sv
// +--------------------------------------------------------------------+
// | lfsr10 : seeded 10-bit Fibonacci LFSR (taps 10,7) with enable      |
// | Rev 1.0  : initial release                                         |
// +--------------------------------------------------------------------+
`default_nettype none

module lfsr10 #(
  parameter logic [9:0] SEED = 10'h2A5
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       en,
  output logic [9:0] value
);

  logic [9:0] lfsr_q;
  logic [9:0] lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (en) lfsr_d = {lfsr_q[8:0], lfsr_q[9] ^ lfsr_q[6]};
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) lfsr_q <= SEED;
    else       lfsr_q <= lfsr_d;
  end

  assign value = lfsr_q;

endmodule

`default_nettype wire

// File: rtl/game_sequencer.sv
// +--------------------------------------------------------------------+
// | game_sequencer : IDLE/PLAY/OVER control, spawn timing, score/speed |
// | Optional macro PAUSE_EN adds a level-sensitive pause input.        |
// | Rev 1.0  : initial release                                         |
// +--------------------------------------------------------------------+
`default_nettype none

module game_sequencer
  import game_pkg::*;
#(
  parameter int         SPAWN_FRAMES  = 90,
  parameter int         X_MAX         = 607,
  parameter int         SPEEDUP_SCORE = 8,
  parameter logic [9:0] LFSR_SEED     = 10'h2A5
) (
  input  logic               CLOCK_50,
  input  logic               reset,
  input  logic               start,
  input  logic               vsync,
  input  logic               player_drawing,
  input  logic               obstacle_drawing,
  input  logic               obstacle_done,
`ifdef PAUSE_EN
  input  logic               pause,
`endif
  output logic               obstacle_trigger,
  output logic [9:0]         obstacle_start_x,
  output logic [2:0]         speed,
  output logic               game_over,
  output logic [SCORE_W-1:0] score,
  output logic [SCORE_W-1:0] max_score,
  output logic               frame_tick
);

  localparam logic [12:0]        BASE_PERIOD  = 13'(SPAWN_FRAMES);
  localparam logic [12:0]        MIN_PERIOD   = 13'd16;
  localparam logic [9:0]         X_LIMIT      = 10'(X_MAX);
  localparam logic [SCORE_W-1:0] SCORE_SAT    = '1;
  localparam logic [SCORE_W-1:0] SPEEDUP_STEP = SCORE_W'(SPEEDUP_SCORE);
  localparam logic [2:0]         SPEED_TOP    = 3'(SPEED_MAX);

  state_e             state_q, state_d;
  logic               game_over_q, game_over_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [SCORE_W-1:0] max_score_q, max_score_d;
  logic [2:0]         speed_q, speed_d;
  logic [9:0]         frame_cnt_q, frame_cnt_d;
  logic               coll_q, coll_d;
  logic               trig_q, trig_d;
  logic [9:0]         start_x_q, start_x_d;
  logic               tick_q, tick_d;
  logic               vs_meta_q, vs_meta_d;
  logic               vs_sync_q, vs_sync_d;
  logic               vs_prev_q, vs_prev_d;
  logic               start_prev_q, start_prev_d;

  logic [9:0]         lfsr;
  logic [9:0]         cand;
  logic [12:0]        reduce;
  logic [12:0]        period;
  logic [SCORE_W-1:0] score_inc;
  logic               start_rise;
  logic               paused;

`ifdef PAUSE_EN
  assign paused = pause;
`else
  assign paused = 1'b0;
`endif

  lfsr10 #(.SEED(LFSR_SEED)) u_lfsr (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .en       (1'b1),
    .value    (lfsr)
  );

  assign cand       = spawn_col(lfsr, X_LIMIT);
  assign start_rise = start & ~start_prev_q;
  assign score_inc  = score_q + SCORE_W'(1);
  assign reduce     = {7'd0, speed_q, 3'd0} - 13'd8;

  // The 16-frame floor only bounds the speed-shortened period; base speed
  // uses SPAWN_FRAMES as configured.
  always_comb begin
    if (speed_q == 3'd1)                    period = BASE_PERIOD;
    else if (BASE_PERIOD < reduce + MIN_PERIOD) period = MIN_PERIOD;
    else                                    period = BASE_PERIOD - reduce;
  end

  always_comb begin
    state_d      = state_q;
    game_over_d  = game_over_q;
    score_d      = score_q;
    max_score_d  = max_score_q;
    speed_d      = speed_q;
    frame_cnt_d  = frame_cnt_q;
    coll_d       = coll_q;
    trig_d       = 1'b0;
    start_x_d    = start_x_q;
    vs_meta_d    = vsync;
    vs_sync_d    = vs_meta_q;
    vs_prev_d    = vs_sync_q;
    tick_d       = vs_prev_q & ~vs_sync_q;
    start_prev_d = start;

    case (state_q)
      IDLE, OVER: begin
        game_over_d = 1'b1;
        if (state_q == OVER && score_q > max_score_q) max_score_d = score_q;
        if (start_rise) begin
          state_d     = PLAY;
          game_over_d = 1'b0;
          score_d     = '0;
          speed_d     = 3'd1;
          frame_cnt_d = '0;
          coll_d      = 1'b0;
        end
      end
      PLAY: begin
        game_over_d = 1'b0;
        if (!paused) begin
          if (player_drawing & obstacle_drawing) coll_d = 1'b1;
          if ({3'd0, frame_cnt_q} >= period) begin
            trig_d      = 1'b1;
            start_x_d   = cand;
            frame_cnt_d = tick_q ? 10'd1 : 10'd0;
          end else if (tick_q) begin
            frame_cnt_d = frame_cnt_q + 10'd1;
          end
          if (obstacle_done && score_q != SCORE_SAT) begin
            score_d = score_inc;
            if ((score_inc % SPEEDUP_STEP) == '0 && speed_q != SPEED_TOP)
              speed_d = speed_q + 3'd1;
          end
          if (coll_q && tick_q) begin
            state_d     = OVER;
            game_over_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q      <= IDLE;
      game_over_q  <= 1'b1;
      score_q      <= '0;
      max_score_q  <= '0;
      speed_q      <= 3'd1;
      frame_cnt_q  <= '0;
      coll_q       <= 1'b0;
      trig_q       <= 1'b0;
      start_x_q    <= '0;
      tick_q       <= 1'b0;
      vs_meta_q    <= 1'b0;
      vs_sync_q    <= 1'b0;
      vs_prev_q    <= 1'b0;
      start_prev_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      game_over_q  <= game_over_d;
      score_q      <= score_d;
      max_score_q  <= max_score_d;
      speed_q      <= speed_d;
      frame_cnt_q  <= frame_cnt_d;
      coll_q       <= coll_d;
      trig_q       <= trig_d;
      start_x_q    <= start_x_d;
      tick_q       <= tick_d;
      vs_meta_q    <= vs_meta_d;
      vs_sync_q    <= vs_sync_d;
      vs_prev_q    <= vs_prev_d;
      start_prev_q <= start_prev_d;
    end
  end

  assign obstacle_trigger = trig_q;
  assign obstacle_start_x = start_x_q;
  assign speed            = speed_q;
  assign game_over        = game_over_q;
  assign score            = score_q;
  assign max_score        = max_score_q;
  assign frame_tick       = tick_q;

endmodule

`default_nettype wire

// File: tb/tb_game_sequencer.sv
// +--------------------------------------------------------------------+
// | tb_game_sequencer : directed self-checking bench for game_sequencer|
// | Rev 1.0  : initial release                                         |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_game_sequencer;

  localparam logic [9:0] SEED = 10'h2A5;

  logic       CLOCK_50 = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       vsync = 1'b1;
  logic       player_drawing = 1'b0;
  logic       obstacle_drawing = 1'b0;
  logic       obstacle_done = 1'b0;
  logic       obstacle_trigger;
  logic [9:0] obstacle_start_x;
  logic [2:0] speed;
  logic       game_over;
  logic [6:0] score;
  logic [6:0] max_score;
  logic       frame_tick;

  always #10 CLOCK_50 = ~CLOCK_50;

  game_sequencer #(
    .SPAWN_FRAMES (4)
  ) dut (
    .CLOCK_50         (CLOCK_50),
    .reset            (reset),
    .start            (start),
    .vsync            (vsync),
    .player_drawing   (player_drawing),
    .obstacle_drawing (obstacle_drawing),
    .obstacle_done    (obstacle_done),
    .obstacle_trigger (obstacle_trigger),
    .obstacle_start_x (obstacle_start_x),
    .speed            (speed),
    .game_over        (game_over),
    .score            (score),
    .max_score        (max_score),
    .frame_tick       (frame_tick)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int tick_cnt = 0;
  int trig_cnt = 0;
  int x_bad    = 0;
  int trig_tick[$];

  // Reference LFSR: spawn column expected for a trigger registered at edge E
  // is derived from the LFSR value held just before E.
  logic [9:0] m_lfsr;
  logic [9:0] m_cand_prev;
  always @(posedge CLOCK_50) begin
    if (reset) m_lfsr <= SEED;
    else       m_lfsr <= {m_lfsr[8:0], m_lfsr[9] ^ m_lfsr[6]};
    m_cand_prev <= (m_lfsr > 10'd607) ? m_lfsr - 10'd608 : m_lfsr;
  end

  always @(negedge CLOCK_50) begin
    if (frame_tick === 1'b1) tick_cnt++;
    if (obstacle_trigger === 1'b1) begin
      trig_cnt++;
      trig_tick.push_back(tick_cnt);
      if (obstacle_start_x !== m_cand_prev || obstacle_start_x > 10'd607) x_bad++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge CLOCK_50);
  endtask

  task automatic frame();
    @(negedge CLOCK_50);
    vsync = 1'b0;
    cycles(3);
    vsync = 1'b1;
    cycles(13);
  endtask

  task automatic pulse_done();
    @(negedge CLOCK_50);
    obstacle_done = 1'b1;
    @(negedge CLOCK_50);
    obstacle_done = 1'b0;
    cycles(1);
  endtask

  initial begin
    reset = 1'b1;
    cycles(5);
    chk("rst_game_over", game_over, 1);
    chk("rst_score", score, 0);
    chk("rst_max_score", max_score, 0);
    chk("rst_speed", speed, 1);
    chk("rst_trigger", obstacle_trigger, 0);
    chk("rst_start_x", obstacle_start_x, 0);
    chk("rst_frame_tick", frame_tick, 0);
    reset = 1'b0;
    cycles(2);

    pulse_done();
    chk("idle_done_ignored", score, 0);

    start = 1'b1;
    cycles(1);
    chk("start_to_play", game_over, 0);
    start = 1'b0;

    // Base period of 4 frames: spawns follow ticks 4 and 8.
    repeat (10) frame();
    cycles(2);
    chk("tick_count_10", tick_cnt, 10);
    chk("trig_count_10", trig_cnt, 2);
    chk("trig0_at_tick", trig_tick.size() > 0 ? trig_tick[0] : -1, 4);
    chk("trig1_at_tick", trig_tick.size() > 1 ? trig_tick[1] : -1, 8);
    chk("start_x_values", x_bad, 0);

    repeat (8) pulse_done();
    chk("score_8", score, 8);
    chk("speed_2", speed, 2);

    // Counter sits at 2; the clamped 16-frame period needs 14 more ticks.
    repeat (13) frame();
    chk("no_spawn_before_16", trig_cnt, 2);
    frame();
    chk("spawn_at_16", trig_cnt, 3);
    chk("trig2_at_tick", trig_tick.size() > 2 ? trig_tick[2] : -1, 24);
    chk("start_x_values_2", x_bad, 0);

    start = 1'b1;
    cycles(2);
    @(negedge CLOCK_50);
    player_drawing   = 1'b1;
    obstacle_drawing = 1'b1;
    @(negedge CLOCK_50);
    player_drawing   = 1'b0;
    obstacle_drawing = 1'b0;
    cycles(1);
    chk("collision_waits_tick", game_over, 0);
    frame();
    chk("over_after_tick", game_over, 1);
    chk("max_score_8", max_score, 8);
    cycles(5);
    chk("held_start_no_restart", game_over, 1);

    start = 1'b0;
    cycles(1);
    start = 1'b1;
    cycles(1);
    chk("restart_play", game_over, 0);
    chk("restart_score", score, 0);
    chk("restart_max_kept", max_score, 8);
    chk("restart_speed", speed, 1);
    start = 1'b0;

    repeat (130) pulse_done();
    chk("score_saturates", score, 127);
    chk("speed_saturates", speed, 7);
    chk("max_in_play", max_score, 8);

    @(negedge CLOCK_50);
    reset = 1'b1;
    cycles(1);
    chk("midgame_rst_game_over", game_over, 1);
    chk("midgame_rst_score", score, 0);
    chk("midgame_rst_max", max_score, 0);
    chk("midgame_rst_speed", speed, 1);
    chk("midgame_rst_start_x", obstacle_start_x, 0);
    chk("midgame_rst_trigger", obstacle_trigger, 0);
    reset = 1'b0;
    cycles(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
